// File: rtl/rs422_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// rs422_tx_arbiter_if
// Bundles the frame-source side, the UART TX side and the status outputs of
// the RS422 transmit arbiter.
//   bus_enable : bus free indication from the timing controller
//   req        : per-source frame request (level)
//   src_valid  : per-source byte valid
//   src_data   : per-source byte, source i at [i*DW +: DW]
//   src_last   : per-source end-of-frame marker, qualified by src_valid
//   src_ready  : per-source byte accepted
//   grant      : one-hot current owner, 0 when none
//   tx_en      : RS422 driver enable / frame active
//   tx_valid   : byte valid to UART TX
//   tx_data    : byte to UART TX
//   tx_ready   : UART TX accepts byte
//   tx_busy    : UART shift register not idle
//   abort      : one-cycle pulse on stall abort
//   busy       : arbiter not idle
// The master modport is the arbiter's view; slave is the environment's view.
// ---------------------------------------------------------------------------
interface rs422_tx_arbiter_if #(
    parameter int unsigned N  = 2,
    parameter int unsigned DW = 8
);
    logic            bus_enable;
    logic [N-1:0]    req;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_last;
    logic [N-1:0]    src_ready;
    logic [N-1:0]    grant;
    logic            tx_en;
    logic            tx_valid;
    logic [DW-1:0]   tx_data;
    logic            tx_ready;
    logic            tx_busy;
    logic            abort;
    logic            busy;

    modport master (
        input  bus_enable, req, src_valid, src_data, src_last, tx_ready, tx_busy,
        output src_ready, grant, tx_en, tx_valid, tx_data, abort, busy
    );

    modport slave (
        output bus_enable, req, src_valid, src_data, src_last, tx_ready, tx_busy,
        input  src_ready, grant, tx_en, tx_valid, tx_data, abort, busy
    );
endinterface

// File: rtl/rs422_tx_arbiter.sv
// ---------------------------------------------------------------------------
// rs422_tx_arbiter
// Round-robin sharing of one RS422 UART transmitter between N frame sources.
// A grant is only issued from IDLE while the bus is free; the owner then
// streams bytes until src_last (or a stall abort), the frame drains until the
// UART shift register is idle, tx_en falls, and a fixed gap is enforced before
// the next arbitration.
//   i_clk : system clock
//   i_rst : synchronous reset, active-high
//   bus   : rs422_tx_arbiter_if.master (source, UART and status signals)
// ---------------------------------------------------------------------------
module rs422_tx_arbiter #(
    parameter int unsigned N         = 2,
    parameter int unsigned DW        = 8,
    parameter int unsigned GAP_CYC   = 120,
    parameter int unsigned STALL_CYC = 1200
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rs422_tx_arbiter_if.master bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = $clog2(STALL_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SEND  = 4'b0010,
        S_DRAIN = 4'b0100,
        S_GAP   = 4'b1000
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [IW-1:0] r_gidx;
    logic [IW-1:0] r_last;
    logic [N-1:0]  r_grant;
    logic          r_tx_en;
    logic          r_abort;
    logic [SW-1:0] r_stall;
    logic [GW-1:0] r_gap;

    logic [IW-1:0] w_pick;
    logic          w_pick_ok;
    logic [N-1:0]  w_pick_oh;
    logic          w_tx_valid;
    logic [DW-1:0] w_tx_data;
    logic [N-1:0]  w_src_ready;
    logic          w_last_g;
    logic          w_hs;
    logic          w_stall_hit;
    logic          w_gap_done;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered datapath: grant, tx_en, abort pulse, stall and gap counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gidx  <= '0;
            r_last  <= IW'(N - 1);
            r_grant <= '0;
            r_tx_en <= 1'b0;
            r_abort <= 1'b0;
            r_stall <= '0;
            r_gap   <= '0;
        end else begin
            r_abort <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_pick_ok) begin
                        r_gidx  <= w_pick;
                        r_last  <= w_pick;
                        r_grant <= w_pick_oh;
                        r_tx_en <= 1'b1;
                        r_stall <= '0;
                    end
                end
                S_SEND: begin
                    if (w_stall_hit) begin
                        r_abort <= 1'b1;
                        r_stall <= '0;
                    end else if (w_tx_valid) begin
                        r_stall <= '0;
                    end else begin
                        r_stall <= r_stall + SW'(1);
                    end
                end
                S_DRAIN: begin
                    if (!bus.tx_busy) begin
                        r_tx_en <= 1'b0;
                        r_grant <= '0;
                        r_gap   <= '0;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GW'(1);
                end
                default: ;
            endcase
        end
    end

    // Next-state logic, including the rotating-pointer search that starts
    // one past the previous owner and wraps modulo N.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_pick_ok = 1'b0;
        w_pick    = '0;
        w_pick_oh = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(r_last) + 1 + i;
            if (idx >= N) idx = idx - N;
            if (idx >= N) idx = idx - N;
            for (int unsigned j = 0; j < N; j++) begin
                if (!w_pick_ok && (j == idx) && bus.req[j]) begin
                    w_pick_ok = 1'b1;
                    w_pick    = IW'(j);
                end
            end
        end
        w_pick_ok = w_pick_ok & bus.bus_enable;
        for (int unsigned j = 0; j < N; j++) begin
            w_pick_oh[j] = w_pick_ok && (w_pick == IW'(j));
        end

        w_hs        = w_tx_valid & bus.tx_ready;
        w_stall_hit = (r_state == S_SEND) && !w_tx_valid &&
                      (r_stall == SW'(STALL_CYC - 1));
        w_gap_done  = (r_gap == GW'(GAP_CYC - 1));

        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_pick_ok) w_next = S_SEND;
            S_SEND:  if ((w_hs && w_last_g) || w_stall_hit) w_next = S_DRAIN;
            S_DRAIN: if (!bus.tx_busy) w_next = S_GAP;
            S_GAP:   if (w_gap_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic: byte path muxed from the registered owner index in SEND
    always_comb begin
        w_tx_valid  = 1'b0;
        w_tx_data   = '0;
        w_src_ready = '0;
        w_last_g    = 1'b0;
        if (r_state == S_SEND) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (r_gidx == IW'(i)) begin
                    w_tx_valid     = bus.src_valid[i];
                    w_tx_data      = bus.src_data[i*DW +: DW];
                    w_src_ready[i] = bus.tx_ready;
                    w_last_g       = bus.src_last[i];
                end
            end
        end
    end

    assign bus.tx_valid  = w_tx_valid;
    assign bus.tx_data   = w_tx_data;
    assign bus.src_ready = w_src_ready;
    assign bus.grant     = r_grant;
    assign bus.tx_en     = r_tx_en;
    assign bus.abort     = r_abort;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rs422_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rs422_tx_arbiter
// Directed sequence with randomized byte content, valid gaps, back-pressure
// and request masks. Expected owners come from a round-robin pointer model,
// expected byte streams from per-frame queues, expected timing from the
// arbitration, stall and gap rules expressed in cycle counts.
// ---------------------------------------------------------------------------
module tb_rs422_tx_arbiter;
    localparam int unsigned N         = 2;
    localparam int unsigned DW        = 8;
    localparam int unsigned GAP_CYC   = 120;
    localparam int unsigned STALL_CYC = 1200;
    localparam int          WAIT_MAX  = 5000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs422_tx_arbiter_if #(.N(N), .DW(DW)) bus ();

    rs422_tx_arbiter #(
        .N(N), .DW(DW), .GAP_CYC(GAP_CYC), .STALL_CYC(STALL_CYC)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Monitor: records every accepted UART byte and every abort cycle
    logic [7:0]  cap_q[$];
    int unsigned abort_seen = 0;
    int          rd_ptr     = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.tx_valid && bus.tx_ready) cap_q.push_back(bus.tx_data);
            if (bus.abort) abort_seen++;
        end
    end

    // Round-robin reference: index of the previous owner
    int rr_last;

    function automatic int rr_pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (rr_last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.bus_enable = 1'b0;
        bus.req        = '0;
        bus.src_valid  = '0;
        bus.src_data   = '0;
        bus.src_last   = '0;
        bus.tx_ready   = 1'b0;
        bus.tx_busy    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        check("rst_grant", bus.grant, 0);
        check("rst_tx_en", bus.tx_en, 0);
        check("rst_abort", bus.abort, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_src_ready", bus.src_ready, 0);
        rst     = 1'b0;
        rr_last = N - 1;
        rd_ptr  = cap_q.size();
    endtask

    // Raise requests and wait (bounded) for the grant; exp_lat is the number
    // of edges from now until the grant is visible.
    task automatic start_frame(input logic [N-1:0] r, input int exp_lat, output int src);
        int cyc;
        bit bad;
        cyc            = 0;
        bad            = 1'b0;
        bus.req        = r;
        bus.bus_enable = 1'b1;
        src            = rr_pick(r);
        while (bus.grant == '0 && cyc < WAIT_MAX) begin
            tick();
            cyc++;
            if (bus.grant == '0 && bus.tx_en) bad = 1'b1;
        end
        check("grant_latency", cyc, exp_lat);
        check("tx_en_before_grant", bad, 0);
        check("grant_owner", bus.grant, oh(src));
        check("tx_en_with_grant", bus.tx_en, 1);
        rr_last = src;
    endtask

    // Stream the bytes of b from source src. mode 0: tx_ready=1, 1: toggling,
    // 2: random. Non-granted sources, req and bus_enable are scrambled to show
    // they have no effect on the running frame.
    task automatic stream(input int src, input logic [7:0] b[$], input int mode,
                          input bit rand_valid, input bit mark_last);
        int k, guard;
        bit tog, hs;
        logic [N-1:0] exp_rdy;
        k     = 0;
        guard = 0;
        tog   = 1'b1;
        bus.tx_busy = 1'b1;
        while (k < b.size() && guard < 1000) begin
            bus.src_valid = N'($urandom);
            bus.src_valid[src] = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.src_data = (N*DW)'($urandom);
            bus.src_data[src*DW +: DW] = b[k];
            bus.src_last = N'($urandom);
            bus.src_last[src] = mark_last && (k == b.size() - 1);
            case (mode)
                0:       bus.tx_ready = 1'b1;
                1:       begin bus.tx_ready = tog; tog = ~tog; end
                default: bus.tx_ready = 1'($urandom);
            endcase
            bus.req        = N'($urandom);
            bus.bus_enable = 1'($urandom);
            #1;
            exp_rdy      = '0;
            exp_rdy[src] = bus.tx_ready;
            check("src_ready_mirror", bus.src_ready, exp_rdy);
            check("tx_valid", bus.tx_valid, bus.src_valid[src]);
            if (bus.src_valid[src]) check("tx_data", bus.tx_data, b[k]);
            hs = bus.src_valid[src] && bus.tx_ready;
            tick();
            if (hs) k++;
            guard++;
        end
        check("frame_bytes_sent", k, b.size());
        bus.src_valid  = '0;
        bus.src_last   = '0;
        bus.req        = '0;
        bus.bus_enable = 1'b1;
    endtask

    task automatic check_bytes(input logic [7:0] b[$]);
        check("byte_count", cap_q.size() - rd_ptr, b.size());
        for (int i = 0; i < b.size(); i++) begin
            if (rd_ptr + i < cap_q.size()) check("byte_value", cap_q[rd_ptr + i], b[i]);
        end
        rd_ptr = cap_q.size();
    endtask

    // UART still shifting for nbusy cycles, then idle: tx_en must hold until
    // the first idle cycle and fall on the following edge.
    task automatic drain(input int nbusy, input int src);
        for (int i = 0; i < nbusy; i++) begin
            bus.tx_busy  = 1'b1;
            bus.tx_ready = 1'($urandom);
            #1;
            check("drain_tx_en", bus.tx_en, 1);
            check("drain_grant", bus.grant, oh(src));
            check("drain_tx_valid", bus.tx_valid, 0);
            tick();
        end
        bus.tx_busy = 1'b0;
        #1;
        check("drain_tx_en_last", bus.tx_en, 1);
        tick();
        check("fall_tx_en", bus.tx_en, 0);
        check("fall_grant", bus.grant, 0);
        check("gap_busy", bus.busy, 1);
    endtask

    logic [7:0] fq[$];
    int         src;
    int         t;
    bit         bad;
    int unsigned ab0;

    initial begin
        idle_inputs();

        // Reset state
        do_reset();

        // Single frame A5 5A C3
        start_frame(2'b01, 1, src);
        fq.delete();
        fq.push_back(8'hA5); fq.push_back(8'h5A); fq.push_back(8'hC3);
        stream(src, fq, 0, 1'b0, 1'b1);
        check_bytes(fq);
        drain(3, src);

        // Bus not free: request waits, grant follows bus_enable by one edge
        bus.bus_enable = 1'b0;
        bus.req        = 2'b10;
        bad            = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (bus.grant != '0 || bus.tx_en) bad = 1'b1;
        end
        check("bus_busy_no_grant", bad, 0);
        bus.bus_enable = 1'b1;
        src = rr_pick(2'b10);
        tick();
        check("bus_free_grant", bus.grant, oh(src));
        check("bus_free_tx_en", bus.tx_en, 1);
        rr_last = src;

        // Back-pressure: tx_ready toggles 1,0,1,0
        fq.delete();
        repeat (4) fq.push_back(8'($urandom));
        stream(src, fq, 1, 1'b0, 1'b1);
        check_bytes(fq);
        drain(2, src);

        // Contention after reset, then random request masks
        do_reset();
        for (int f = 0; f < 10; f++) begin
            logic [N-1:0] r;
            r = (f < 4) ? 2'b11 : N'($urandom_range(1, 3));
            start_frame(r, (f == 0) ? 1 : GAP_CYC + 1, src);
            fq.delete();
            repeat ($urandom_range(1, 3)) fq.push_back(8'($urandom));
            stream(src, fq, 2, 1'b1, 1'b1);
            check_bytes(fq);
            drain($urandom_range(0, 4), src);
        end

        // Stall abort after one accepted byte
        start_frame(2'b01, GAP_CYC + 1, src);
        fq.delete();
        fq.push_back(8'($urandom));
        stream(src, fq, 0, 1'b0, 1'b0);
        ab0 = abort_seen;
        t   = 0;
        while (!bus.abort && t < STALL_CYC + 50) begin
            bus.tx_ready = 1'($urandom);
            tick();
            t++;
        end
        check("abort_cycle", t, STALL_CYC);
        check_bytes(fq);
        drain(3, src);
        check("abort_once", abort_seen - ab0, 1);
        start_frame(2'b11, GAP_CYC + 1, src);
        check("after_abort_owner", src, 1);
        fq.delete();
        repeat (2) fq.push_back(8'($urandom));
        stream(src, fq, 2, 1'b0, 1'b1);
        check_bytes(fq);
        drain(1, src);

        // Reset in the middle of a frame
        start_frame(2'b11, GAP_CYC + 1, src);
        fq.delete();
        fq.push_back(8'($urandom));
        stream(src, fq, 0, 1'b0, 1'b0);
        bus.src_valid[src]         = 1'b1;
        bus.src_data[src*DW +: DW] = 8'($urandom);
        bus.tx_ready               = 1'b0;
        bus.tx_busy                = 1'b1;
        rst                        = 1'b1;
        tick();
        check("midrst_tx_en", bus.tx_en, 0);
        check("midrst_grant", bus.grant, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_abort", bus.abort, 0);
        rst            = 1'b0;
        rr_last        = N - 1;
        bus.src_valid  = '0;
        bus.tx_busy    = 1'b0;
        bus.req        = 2'b11;
        bus.bus_enable = 1'b1;
        src            = rr_pick(2'b11);
        tick();
        check("post_rst_grant", bus.grant, oh(src));
        check("post_rst_tx_en", bus.tx_en, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rs422_tx_arbiter.md
Name: rs422_tx_arbiter

Overview:
Shares the single RS422 UART transmitter between N frame sources, e.g. the command-reply path and the science-data path. Arbitration is round-robin. A grant is issued only while the bus timing controller reports the bus free (bus_enable high). The arbiter owns tx_en for the whole frame; the falling edge of tx_en is the timing controller's send-done event. Each frame is followed by a fixed inter-frame gap, and a frame is aborted if its source stalls mid-frame.

Parameters:
N, 2, number of requesters (2..8)
DW, 8, byte width
GAP_CYC, 120, idle cycles enforced after tx_en falls (10 us at 12 MHz)
STALL_CYC, 1200, consecutive SEND cycles without src_valid before abort (100 us)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
bus_enable  in  1  bus free, from timing controller ENABLE
req  in  N  per-source frame request, level
src_valid  in  N  per-source byte valid
src_data  in  N*DW  per-source byte, source i at bits [i*DW +: DW]
src_last  in  N  marks last byte of frame, qualified by src_valid
src_ready  out  N  byte accepted by arbiter
grant  out  N  one-hot current owner, 0 when none
tx_en  out  1  RS422 driver enable / frame active
tx_valid  out  1  byte valid to UART TX
tx_data  out  DW  byte to UART TX
tx_ready  in  1  UART TX accepts byte
tx_busy  in  1  UART shift register not idle
abort  out  1  one-cycle pulse on stall abort
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, SEND, DRAIN, GAP. Encoding is one-hot.
- Reset: state IDLE; grant = 0; tx_en = 0; abort = 0; stall and gap counters = 0; last_grant index = N-1, so source 0 wins the first arbitration.
- IDLE:
  - grant = 0, tx_en = 0, tx_valid = 0, src_ready = 0.
  - If bus_enable and |req, select the first requester with req=1 searching from last_grant+1 modulo N.
  - Register grant and last_grant; go to SEND next cycle.
  - If bus_enable = 0, requests wait with no grant.
- SEND:
  - tx_en = 1, registered, high from the first SEND cycle.
  - Combinational mux from the registered grant index g: tx_valid = src_valid[g], tx_data = src_data[g], src_ready[g] = tx_ready. All other src_ready bits = 0.
  - Handshake = tx_valid & tx_ready.
  - Handshake with src_last[g] → DRAIN.
  - Stall counter increments each cycle src_valid[g] = 0 and clears on src_valid[g] = 1. When it reaches STALL_CYC-1: abort = 1 for one cycle, go to DRAIN. Bytes already accepted still shift out.
  - req[g] dropping during SEND is ignored. bus_enable dropping during SEND is ignored, since the arbiter owns the frame once granted.
- DRAIN:
  - tx_valid = 0, src_ready = 0, tx_en held 1, grant held.
  - First cycle with tx_busy = 0 → tx_en = 0 and grant = 0 on the next edge; go to GAP.
  - Zero-byte abort: the stall fired before any byte was accepted. The frame still drains and tx_en falls normally.
- GAP:
  - Counter counts GAP_CYC cycles with tx_en = 0, then → IDLE.
  - New grants are not allowed before GAP completes, even if bus_enable = 1.
- Latency: req to grant = 1 cycle from IDLE with bus_enable high. grant to tx_en = same edge.
- Simultaneous requests are resolved by the rotating pointer only. No fixed priority after the first arbitration.
- Reset mid-frame: immediate return to reset values. The partial frame is lost and tx_en drops on the next edge.
- N=1: round-robin degenerates to always granting source 0.

Test Plan:
- Single frame: req[0]=1, bus_enable=1, 3 bytes 0xA5 0x5A 0xC3 with last on the third, tx_ready=1 → grant=01 one cycle after req; tx_data sequence A5,5A,C3; tx_en falls the first cycle tx_busy=0 after C3; next grant no earlier than 120 cycles later.
- Contention: req=11 held, each source sends 2-byte frames → grants alternate 01,10,01,10; source 0 first after reset.
- Bus not free: req[1]=1, bus_enable=0 for 500 cycles → grant=0, tx_en=0 throughout; grant=10 one cycle after bus_enable rises.
- Stall abort: source 0 sends 1 byte, then src_valid=0 for 1200 cycles → abort pulses exactly once at cycle 1200; tx_en falls after tx_busy clears; source 1 is granted after the gap.
- Backpressure: tx_ready toggles 1,0,1,0 → each byte is accepted exactly once; src_ready[g] mirrors tx_ready; no byte is dropped or duplicated.
- Reset mid-frame: assert rst during the 2nd byte → next edge: tx_en=0, grant=0, busy=0; after release, req=11 → grant=01.
